// File: rtl/cofre_fsm.sv
// Safe lock controller: sequences lock states from local, remote and emergency inputs,
// owns the stored password, the failed-attempt count and the timed-state tick counter.
module cofre_fsm #(
  parameter int               PWD_W       = 4,
  parameter logic [PWD_W-1:0] DEFAULT_PWD = 4'b1010,
  parameter int               AL_TICKS    = 5,
  parameter int               BLOCK_TICKS = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             close_req,
  input  logic             prog_req,
  input  logic             enter,
  input  logic [PWD_W-1:0] code,
  input  logic             emerg,
  output logic [2:0]       estado_atual,
  output logic [2:0]       estado_anterior,
  output logic [1:0]       fail_cnt
);

  // All inputs are single-cycle pulses or levels sampled on the rising edge;
  // there is no valid/ready backpressure, so every pulse is consumed or ignored in its cycle.

  typedef enum logic [2:0] {
    AB = 3'b000,
    AL = 3'b001,
    PF = 3'b010,
    FE = 3'b011,
    E1 = 3'b100,
    E2 = 3'b101,
    BL = 3'b110,
    EM = 3'b111
  } state_t;

  localparam int MAX_T = (AL_TICKS > BLOCK_TICKS) ? AL_TICKS : BLOCK_TICKS;
  localparam int CNT_W = $clog2(MAX_T) + 1;
  localparam logic [CNT_W-1:0] AL_LIM = CNT_W'(AL_TICKS);
  localparam logic [CNT_W-1:0] BL_LIM = CNT_W'(BLOCK_TICKS);

  state_t           state, state_n;
  state_t           prev;
  logic [1:0]       fail, fail_n;
  logic [PWD_W-1:0] pwd, pwd_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             match;

  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  assign match   = (code == pwd);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= AB;
      prev  <= AB;
      fail  <= 2'd0;
      pwd   <= DEFAULT_PWD;
      cnt   <= '0;
    end else begin
      state <= state_n;
      fail  <= fail_n;
      pwd   <= pwd_n;
      cnt   <= cnt_n;
      // Self-loops leave the previous-state record untouched.
      if (state_n != state) prev <= state;
    end
  end

  always_comb begin
    state_n = state;
    fail_n  = fail;
    pwd_n   = pwd;
    cnt_n   = cnt;
    if (state != EM && emerg) begin
      state_n = EM;
    end else begin
      case (state)
        EM: if (!emerg) begin
          state_n = AB;
          fail_n  = 2'd0;
        end
        AB: begin
          if (prog_req) begin
            state_n = PF;
          end else if (close_req) begin
            state_n = AL;
            cnt_n   = '0;
          end
        end
        AL: if (tick) begin
          if (cnt_inc >= AL_LIM) state_n = FE;
          else                   cnt_n   = cnt_inc;
        end
        PF: if (enter) begin
          pwd_n   = code;
          state_n = FE;
        end
        FE, E1, E2: if (enter) begin
          if (match) begin
            state_n = AB;
            fail_n  = 2'd0;
          end else if (state == FE) begin
            state_n = E1;
            fail_n  = 2'd1;
          end else if (state == E1) begin
            state_n = E2;
            fail_n  = 2'd2;
          end else begin
            state_n = BL;
            fail_n  = 2'd3;
            cnt_n   = '0;
          end
        end
        BL: if (tick) begin
          if (cnt_inc >= BL_LIM) begin
            state_n = FE;
            fail_n  = 2'd0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: state_n = AB;
      endcase
    end
  end

  assign estado_atual    = state;
  assign estado_anterior = prev;
  assign fail_cnt        = fail;

endmodule

// File: tb/tb_cofre_fsm.sv
// Directed bench for cofre_fsm: walks the lock through its state sequences and checks
// state, previous state and fail count against hand-computed values.
module tb_cofre_fsm;

  localparam logic [2:0] S_AB = 3'd0, S_AL = 3'd1, S_PF = 3'd2, S_FE = 3'd3,
                         S_E1 = 3'd4, S_E2 = 3'd5, S_BL = 3'd6, S_EM = 3'd7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0, close_req = 1'b0, prog_req = 1'b0, enter = 1'b0, emerg = 1'b0;
  logic [3:0] code = 4'h0;
  logic [2:0] estado_atual, estado_anterior;
  logic [1:0] fail_cnt;

  int checks = 0;
  int failures = 0;
  logic [2:0] exp_q[$];

  cofre_fsm #(.PWD_W(4), .DEFAULT_PWD(4'b1010), .AL_TICKS(5), .BLOCK_TICKS(30)) dut (
    .clk(clk), .reset(reset), .tick(tick), .close_req(close_req), .prog_req(prog_req),
    .enter(enter), .code(code), .emerg(emerg), .estado_atual(estado_atual),
    .estado_anterior(estado_anterior), .fail_cnt(fail_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] a, input logic [2:0] p,
                           input logic [1:0] f);
    check_eq({tag, "_atual"}, {5'd0, estado_atual}, {5'd0, a});
    check_eq({tag, "_ant"}, {5'd0, estado_anterior}, {5'd0, p});
    check_eq({tag, "_fail"}, {6'd0, fail_cnt}, {6'd0, f});
  endtask

  // driver: called at a negedge, holds inputs across one rising edge, returns at next negedge
  task automatic drive(input logic c, input logic p, input logic e, input logic t,
                       input logic [3:0] cd);
    close_req = c; prog_req = p; enter = e; tick = t; code = cd;
    @(negedge clk);
    close_req = 1'b0; prog_req = 1'b0; enter = 1'b0; tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 1, 4'h0);
  endtask

  task automatic to_fe_from_ab();
    drive(1, 0, 0, 0, 4'h0);
    ticks(5);
  endtask

  initial begin
    #3;
    check_all("reset", S_AB, S_AB, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1: close, AL counts five ticks, then FE with anterior AL
    drive(1, 0, 0, 0, 4'h0);
    check_all("t1_al", S_AL, S_AB, 2'd0);
    ticks(4);
    check_all("t1_al4", S_AL, S_AB, 2'd0);
    ticks(1);
    check_all("t1_fe", S_FE, S_AL, 2'd0);
    drive(0, 0, 1, 0, 4'hA);
    check_all("t1_dflt_pwd", S_AB, S_FE, 2'd0);

    // 2: program a new code, then open with it
    drive(0, 1, 0, 0, 4'h0);
    check_all("t2_pf", S_PF, S_AB, 2'd0);
    drive(1, 1, 0, 1, 4'h0);
    check_all("t2_pf_hold", S_PF, S_AB, 2'd0);
    drive(0, 0, 1, 0, 4'h3);
    check_all("t2_fe", S_FE, S_PF, 2'd0);
    drive(0, 0, 1, 0, 4'h3);
    check_all("t2_ab", S_AB, S_FE, 2'd0);

    // 3: three wrong codes escalate to BL, which times out after 30 ticks
    to_fe_from_ab();
    drive(0, 0, 1, 0, 4'h0);
    check_all("t3_e1", S_E1, S_FE, 2'd1);
    drive(0, 0, 1, 0, 4'h3);
    check_all("t3_e1_ok", S_AB, S_E1, 2'd0);
    to_fe_from_ab();
    exp_q.push_back(S_E1); exp_q.push_back(S_E2); exp_q.push_back(S_BL);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 1, 0, 4'h0);
      check_eq("t3_seq", {5'd0, estado_atual}, {5'd0, exp_q.pop_front()});
      check_eq("t3_seq_fail", {6'd0, fail_cnt}, 8'(i));
    end
    drive(0, 0, 1, 0, 4'h3);
    check_all("t3_bl_enter", S_BL, S_E2, 2'd3);
    ticks(29);
    check_all("t3_bl29", S_BL, S_E2, 2'd3);
    ticks(1);
    check_all("t3_bl_fe", S_FE, S_BL, 2'd0);

    // 4: emergency aborts a running block
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 4'h0);
    check_all("t4_bl", S_BL, S_E2, 2'd3);
    ticks(10);
    emerg = 1'b1;
    drive(0, 0, 0, 1, 4'h0);
    check_all("t4_em", S_EM, S_BL, 2'd3);
    ticks(40);
    check_all("t4_em_hold", S_EM, S_BL, 2'd3);
    emerg = 1'b0;
    drive(0, 0, 0, 0, 4'h0);
    check_all("t4_ab", S_AB, S_EM, 2'd0);

    // 5: emergency beats a correct code in the same cycle; stored code is unchanged
    to_fe_from_ab();
    emerg = 1'b1;
    drive(0, 0, 1, 0, 4'h3);
    check_all("t5_em", S_EM, S_FE, 2'd0);
    emerg = 1'b0;
    drive(0, 0, 0, 0, 4'h0);
    check_all("t5_ab", S_AB, S_EM, 2'd0);
    to_fe_from_ab();
    drive(0, 0, 1, 0, 4'h3);
    check_all("t5_pwd", S_AB, S_FE, 2'd0);

    // tick on the entry cycle into AL is not counted
    drive(1, 0, 0, 1, 4'h0);
    ticks(4);
    check_all("t5_entry_tick", S_AL, S_AB, 2'd0);
    ticks(1);
    check_all("t5_entry_fe", S_FE, S_AL, 2'd0);
    drive(0, 0, 1, 0, 4'h3);

    // 6: asynchronous reset mid-AL restores the default code
    drive(1, 0, 0, 0, 4'h0);
    ticks(2);
    #2 reset = 1'b0;
    #1 check_all("t6_async", S_AB, S_AB, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    to_fe_from_ab();
    drive(0, 0, 1, 0, 4'h3);
    check_all("t6_old_pwd", S_E1, S_FE, 2'd1);
    drive(0, 0, 1, 0, 4'hA);
    check_all("t6_dflt_pwd", S_AB, S_E1, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
